pg_serial_adder_seq: RTL
========================

// Module: pg_serial_adder_seq
// PURPOSE
//   Sequences one 4-bit PG adder slice (add_pg_4) over a WIDTH-bit operand pair,
//   one nibble per cycle LSB-first, in place of a full-width combinational adder.
//   Takes an operation over a valid/ready input handshake and returns the sum,
//   carry-out, signed overflow and whole-word group propagate/generate over a
//   valid/ready output handshake. Used as the area-lean add/sub unit ahead of the ALU result mux.
// PARAMETERS
//   WIDTH   16   operand width in bits; multiple of 4, >= 8; NIB = WIDTH/4 slice passes
// PORTS
//   clk        in   1      single clock, all state updates on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operation request
//   in_ready   out  1      block can accept a request (high only in IDLE)
//   in_a       in   WIDTH  operand A
//   in_b       in   WIDTH  operand B
//   in_sub     in   1      1: A - B (B inverted, carry-in forced 1); 0: A + B + in_cin
//   in_cin     in   1      carry-in for add; ignored when in_sub=1
//   out_valid  out  1      result available (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   out_sum    out  WIDTH  A + B_eff + cin, modulo 2^WIDTH
//   out_cout   out  1      carry out of bit WIDTH-1 (for sub: 1 = no borrow)
//   out_ovf    out  1      signed overflow: A[msb]==B_eff[msb] && sum[msb]!=A[msb]
//   out_prop   out  1      AND of all slice prop_out (whole-word propagate)
//   out_gen    out  1      whole-word generate, carry-in independent
// BEHAVIOUR
//   - Reset (rst=1 at edge): state=IDLE; in_ready=1 on next cycle; out_valid=0; out_sum=0;
//     out_cout=0; out_ovf=0; out_prop=0; out_gen=0; nibble index=0. Reset wins over all inputs.
//   - FSM IDLE -> RUN -> DONE -> IDLE.
//     IDLE: in_ready=1. Accept on in_valid&&in_ready: latch A, B_eff = in_sub ? ~in_b : in_b,
//       carry reg = in_sub ? 1 : in_cin, idx=0, P_acc=1, G_acc=0; go RUN.
//     RUN: slice inputs = A[4*idx+:4], B_eff[4*idx+:4], carry reg. Each cycle write
//       sum nibble idx, carry reg <= slice carry_out, P_acc <= P_acc & prop_out,
//       G_acc <= gen_out | (prop_out & G_acc), idx++. After nibble NIB-1 go DONE.
//     DONE: out_valid=1; outputs stable. On out_ready go IDLE (in_ready=1 next cycle).
//   - Latency: accept edge to out_valid = NIB+1 clock edges (WIDTH=16: out_valid high 5th cycle after accept).
//     Throughput: one op per NIB+2 cycles with out_ready held high.
//   - No accept while RUN/DONE (in_ready=0); in_valid ignored, requester must hold.
//   - Outputs hold last result after DONE->IDLE until next DONE; out_sum partial bits
//     update during RUN and are valid only while out_valid=1.
//   - out_valid && !out_ready: stay in DONE indefinitely, all outputs frozen.
//   - Operands latched at accept; in_a/in_b changes after accept have no effect.
//   - rst during RUN or DONE: op aborted, no result emitted, reset values as above.
//   - idx wraps never: width = clog2(NIB), compared against NIB-1 exactly.
// TESTING (WIDTH=16)
//   - Reset: rst 2 cycles -> in_ready=1, out_valid=0, all result outputs 0.
//   - Add 0xFFFF+0x0001, cin=0 -> out_sum=0x0000, cout=1, ovf=0, prop=0, gen=1; out_valid exactly 5 cycles after accept.
//   - Sub 0x0005-0x0007 -> out_sum=0xFFFE, cout=0, ovf=0; Sub 0x0007-0x0005 -> 0x0002, cout=1.
//   - Add 0x7FFF+0x0001 -> 0x8000, ovf=1; Add 0x00FF+0xFF00 cin=1 -> 0x0000, cout=1, prop=1, gen=0.
//   - Backpressure: out_ready=0 for 10 cycles -> out_valid stays 1, outputs frozen, in_ready=0, new in_valid ignored.
//   - rst asserted in 2nd RUN cycle -> next cycle IDLE, out_valid never rises; following op 0x1234+0x1111 -> 0x2345.

Source files
------------

// File: rtl/pg_serial_adder_seq.sv
// Serial adder: walks one 4-bit PG lookahead slice across a WIDTH-bit operand
// pair, one nibble per cycle LSB-first, with valid/ready on both sides.

module add_pg_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       prop_out,
  output logic       gen_out
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum      = p ^ c[3:0];
    cout     = c[4];
    prop_out = &p;
    gen_out  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  end

endmodule

// state  | meaning
// S_IDLE | waiting for a request, in_ready high
// S_RUN  | one nibble per cycle through the slice, idx 0..NIB-1
// S_DONE | result presented, waiting for out_ready
module pg_serial_adder_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_prop,
  output logic             out_gen
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic             p_acc;
  logic             g_acc;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    nib_base;
  logic             last_nib;

  logic [3:0] slice_sum;
  logic       slice_cout;
  logic       slice_prop;
  logic       slice_gen;

  assign nib_base = {idx, 2'b00};
  assign last_nib = (idx == IW'(NIB - 1));

  add_pg_4 u_slice (
    .a        (a_q[nib_base +: 4]),
    .b        (b_q[nib_base +: 4]),
    .cin      (carry_q),
    .sum      (slice_sum),
    .cout     (slice_cout),
    .prop_out (slice_prop),
    .gen_out  (slice_gen)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_RUN;
      end
      S_RUN: begin
        if (last_nib) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath; the result flags only load on the final nibble so they keep
  // showing the previous op while the next one is in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      p_acc    <= 1'b1;
      g_acc    <= 1'b0;
      idx      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
      out_prop <= 1'b0;
      out_gen  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_sub ? ~in_b : in_b;
            carry_q <= in_sub ? 1'b1 : in_cin;
            p_acc   <= 1'b1;
            g_acc   <= 1'b0;
            idx     <= '0;
          end
        end
        S_RUN: begin
          out_sum[nib_base +: 4] <= slice_sum;
          carry_q <= slice_cout;
          p_acc   <= p_acc & slice_prop;
          g_acc   <= slice_gen | (slice_prop & g_acc);
          if (last_nib) begin
            idx      <= '0;
            out_cout <= slice_cout;
            out_prop <= p_acc & slice_prop;
            out_gen  <= slice_gen | (slice_prop & g_acc);
            out_ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_sum[3] != a_q[WIDTH-1]);
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
